// File: rtl/wb_regfile.sv
// Write-back stage: selects the write-back value, commits it to x1..x31, serves two
// combinational read ports with optional same-cycle bypass, and counts retired instructions.
module wb_regfile #(
  parameter int unsigned XLEN      = 32,
  parameter bit          BYPASS_EN = 1'b1,
  parameter int unsigned INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [XLEN-1:0]      alu_result,
  input  logic [XLEN-1:0]      mem_read_data,
  input  logic [XLEN-1:0]      pc_plus_4,
  input  logic [4:0]           rd_addr,
  input  logic                 reg_write,
  input  logic [1:0]           wb_sel,
  input  logic                 valid,
  input  logic [4:0]           rs1_addr,
  input  logic [4:0]           rs2_addr,
  output logic [XLEN-1:0]      rs1_data,
  output logic [XLEN-1:0]      rs2_data,
  output logic [XLEN-1:0]      wb_data,
  output logic [4:0]           wb_rd,
  output logic                 wb_we,
  output logic [INSTRET_W-1:0] instret
);

  logic [XLEN-1:0]      regs_q [32];
  logic [XLEN-1:0]      regs_d [32];
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic [XLEN-1:0]      sel_data;
  logic                 commit;

  always_comb begin
    case (wb_sel)
      2'b01:   sel_data = mem_read_data;
      2'b10:   sel_data = pc_plus_4;
      default: sel_data = alu_result;
    endcase
  end

  // Gating with reset_n keeps every forwarding output quiet while reset is held.
  assign commit  = reset_n & valid & reg_write & (rd_addr != 5'd0);
  assign wb_we   = commit;
  assign wb_rd   = commit ? rd_addr : 5'd0;
  assign wb_data = commit ? sel_data : '0;
  assign instret = instret_q;

  always_comb begin
    regs_d = regs_q;
    if (commit) regs_d[rd_addr] = sel_data;
    regs_d[0] = '0;
    instret_d = instret_q + INSTRET_W'(valid);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
      instret_q <= '0;
    end else begin
      regs_q    <= regs_d;
      instret_q <= instret_d;
    end
  end

  // Zero/reset override comes last so an X address under reset still yields 0.
  always_comb begin
    rs1_data = regs_q[rs1_addr];
    if (BYPASS_EN && commit && (rs1_addr == rd_addr)) rs1_data = sel_data;
    if (!reset_n || (rs1_addr == 5'd0)) rs1_data = '0;
  end

  always_comb begin
    rs2_data = regs_q[rs2_addr];
    if (BYPASS_EN && commit && (rs2_addr == rd_addr)) rs2_data = sel_data;
    if (!reset_n || (rs2_addr == 5'd0)) rs2_data = '0;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a bypassing 64-bit-counter instance plus a non-bypassing
// 4-bit-counter instance, checked against a reference model through an expectation queue.
module tb_wb_regfile;
  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [XLEN-1:0] alu_result, mem_read_data, pc_plus_4;
  logic [4:0]      rd_addr, rs1_addr, rs2_addr;
  logic            reg_write, valid, valid_nb;
  logic [1:0]      wb_sel;
  logic [XLEN-1:0] rs1_data, rs2_data, wb_data;
  logic [4:0]      wb_rd;
  logic            wb_we;
  logic [63:0]     instret;
  logic [XLEN-1:0] nb_rs1, nb_rs2, nb_wb_data;
  logic [4:0]      nb_wb_rd;
  logic            nb_wb_we;
  logic [3:0]      nb_instret;

  always #5 clk = ~clk;

  wb_regfile #(.XLEN(XLEN), .BYPASS_EN(1'b1), .INSTRET_W(64)) dut (
    .clk(clk), .reset_n(reset_n), .alu_result(alu_result), .mem_read_data(mem_read_data),
    .pc_plus_4(pc_plus_4), .rd_addr(rd_addr), .reg_write(reg_write), .wb_sel(wb_sel),
    .valid(valid), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we), .instret(instret));

  wb_regfile #(.XLEN(XLEN), .BYPASS_EN(1'b0), .INSTRET_W(4)) dut_nb (
    .clk(clk), .reset_n(reset_n), .alu_result(alu_result), .mem_read_data(mem_read_data),
    .pc_plus_4(pc_plus_4), .rd_addr(rd_addr), .reg_write(reg_write), .wb_sel(wb_sel),
    .valid(valid_nb), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(nb_rs1),
    .rs2_data(nb_rs2), .wb_data(nb_wb_data), .wb_rd(nb_wb_rd), .wb_we(nb_wb_we),
    .instret(nb_instret));

  // Reference model (shared register contents: both instances see identical writes).
  logic [XLEN-1:0] mdl [32];
  logic [63:0]     mdl_cnt;
  logic [3:0]      mdl_cnt4;
  logic [63:0]     exp_q [$];
  int              n_pass = 0;
  int              n_total = 0;

  function automatic logic [XLEN-1:0] model_sel(input logic [1:0] s, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] m, input logic [XLEN-1:0] p);
    case (s)
      2'b01:   return m;
      2'b10:   return p;
      default: return a;
    endcase
  endfunction

  function automatic logic model_we();
    return valid && reg_write && (rd_addr != 5'd0);
  endfunction

  task automatic expect_val(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [63:0] obs);
    logic [63:0] exp;
    n_total++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: observed=%h but scoreboard queue empty", tag, obs);
      return;
    end
    exp = exp_q.pop_front();
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  // Selected source carries v; the others carry distinct garbage to expose a bad mux.
  task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [XLEN-1:0] val);
    valid = v; valid_nb = v; reg_write = we; rd_addr = rd; wb_sel = sel;
    alu_result    = (sel == 2'b00 || sel == 2'b11) ? val : val ^ 32'h0F0F_0F0F;
    mem_read_data = (sel == 2'b01) ? val : val ^ 32'h3333_3333;
    pc_plus_4     = (sel == 2'b10) ? val : val ^ 32'h5555_AAAA;
  endtask

  task automatic idle();
    valid = 1'b0; valid_nb = 1'b0; reg_write = 1'b0; rd_addr = 5'd0; wb_sel = 2'b00;
  endtask

  task automatic tick();
    logic            we;
    logic [4:0]      rd;
    logic [XLEN-1:0] val;
    we  = model_we();
    rd  = rd_addr;
    val = model_sel(wb_sel, alu_result, mem_read_data, pc_plus_4);
    @(posedge clk);
    if (we) mdl[rd] = val;
    if (valid) mdl_cnt = mdl_cnt + 64'd1;
    if (valid_nb) mdl_cnt4 = mdl_cnt4 + 4'd1;
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    mdl_cnt = '0; mdl_cnt4 = '0;
  endtask

  task automatic read_check(input string tag, input logic [4:0] a);
    rs1_addr = a; rs2_addr = a; #1;
    expect_val(64'(mdl[a])); check({tag, "_rs1"}, 64'(rs1_data));
    expect_val(64'(mdl[a])); check({tag, "_rs2"}, 64'(rs2_data));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    reset_n = 1'b0;
    idle();
    alu_result = '0; mem_read_data = '0; pc_plus_4 = '0;
    rs1_addr = 'x; rs2_addr = 5'd5;
    drive(1'b1, 1'b1, 5'd5, 2'b00, 32'hCAFE_F00D);
    #12;
    expect_val('0); check("rst_rs1_xaddr", 64'(rs1_data));
    expect_val('0); check("rst_rs2", 64'(rs2_data));
    expect_val('0); check("rst_wb_data", 64'(wb_data));
    expect_val('0); check("rst_wb_rd", 64'(wb_rd));
    expect_val('0); check("rst_wb_we", 64'(wb_we));
    idle();
    @(negedge clk); reset_n = 1'b1; #1;

    for (int a = 0; a < 32; a++) read_check("post_rst", 5'(a));
    expect_val(mdl_cnt); check("post_rst_instret", instret);
    expect_val('0); check("post_rst_wb_we", 64'(wb_we));

    // Same-cycle bypass on both ports; the non-bypass instance still shows the old value.
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd5, 2'b00, 32'hDEAD_BEEF);
    rs1_addr = 5'd5; rs2_addr = 5'd5; #1;
    expect_val(64'h0000_0000_DEAD_BEEF); check("bypass_rs1", 64'(rs1_data));
    expect_val(64'h0000_0000_DEAD_BEEF); check("bypass_rs2", 64'(rs2_data));
    expect_val(64'(mdl[5])); check("nobypass_rs1_old", 64'(nb_rs1));
    expect_val(64'd1); check("bypass_wb_we", 64'(wb_we));
    expect_val(64'd5); check("bypass_wb_rd", 64'(wb_rd));
    expect_val(64'h0000_0000_DEAD_BEEF); check("bypass_wb_data", 64'(wb_data));
    tick();
    idle();
    rs1_addr = 5'd0; rs2_addr = 5'd5; #1;
    expect_val(64'(mdl[5])); check("x5_after_commit", 64'(rs2_data));
    expect_val(64'(mdl[5])); check("nobypass_x5_after", 64'(nb_rs2));
    expect_val(mdl_cnt); check("instret_one", instret);

    // Sequential writes through each write-back source.
    drive(1'b1, 1'b1, 5'd7, 2'b01, 32'h1234_5678); tick();
    drive(1'b1, 1'b1, 5'd1, 2'b10, 32'h0000_0104); tick();
    drive(1'b1, 1'b1, 5'd2, 2'b11, 32'hA5A5_A5A5); tick();
    idle();
    read_check("x7", 5'd7);
    read_check("x1", 5'd1);
    read_check("x2", 5'd2);
    expect_val(mdl_cnt); check("instret_seq", instret);

    // Write to x0 is dropped but still retires.
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd0, 2'b00, 32'hFFFF_FFFF);
    rs1_addr = 5'd0; #1;
    expect_val('0); check("x0_rs1", 64'(rs1_data));
    expect_val('0); check("x0_wb_we", 64'(wb_we));
    expect_val('0); check("x0_wb_rd", 64'(wb_rd));
    expect_val('0); check("x0_wb_data", 64'(wb_data));
    tick();
    idle();
    read_check("x0_after", 5'd0);
    expect_val(mdl_cnt); check("x0_instret", instret);

    // Bubble with reg_write set: no write, no count.
    @(negedge clk);
    drive(1'b0, 1'b1, 5'd3, 2'b00, 32'h0000_0055);
    rs1_addr = 5'd3; #1;
    expect_val('0); check("bubble_wb_we", 64'(wb_we));
    expect_val('0); check("bubble_no_bypass", 64'(rs1_data));
    tick();
    idle();
    read_check("bubble_x3", 5'd3);
    expect_val(mdl_cnt); check("bubble_instret", instret);

    // Narrow counter wrap: reach 15, then one more retirement wraps to 0.
    while (mdl_cnt4 != 4'd15) begin
      valid_nb = 1'b1; tick();
    end
    valid_nb = 1'b0; #1;
    expect_val(64'd15); check("instret4_15", 64'(nb_instret));
    valid_nb = 1'b1; tick(); valid_nb = 1'b0; #1;
    expect_val(64'd0); check("instret4_wrap", 64'(nb_instret));

    // Asynchronous reset between edges with a write pending.
    drive(1'b1, 1'b1, 5'd9, 2'b00, 32'h1111_1111); tick();
    idle();
    read_check("x9_written", 5'd9);
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd9, 2'b00, 32'h2222_2222);
    #2; reset_n = 1'b0; #1;
    model_reset();
    expect_val('0); check("async_rst_x9", 64'(rs1_data));
    expect_val('0); check("async_rst_instret", instret);
    expect_val('0); check("async_rst_instret4", 64'(nb_instret));
    expect_val('0); check("async_rst_wb_we", 64'(wb_we));
    @(posedge clk); #1;
    idle();
    @(negedge clk); reset_n = 1'b1; #1;
    read_check("x9_after_rst", 5'd9);
    expect_val(mdl_cnt); check("instret_after_rst", instret);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
